// File: rtl/servo_pkg.sv
// Shared constants, FSM state and channel enums for the servo slew limiter.
package servo_pkg;
  localparam int unsigned PULSE_W          = 20;
  localparam int unsigned NUM_CH           = 4;
  localparam int unsigned MIN_PULSE_DEF    = 25_000;
  localparam int unsigned MAX_PULSE_DEF    = 125_000;
  localparam int unsigned CENTER_PULSE_DEF = 65_000;
  localparam int unsigned STEP_DEF         = 1_000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_CH_X,
    ST_CH_Y,
    ST_CH_Z,
    ST_CH_G,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    CHAN_X,
    CHAN_Y,
    CHAN_Z,
    CHAN_G
  } chan_e;

  // Channel served by the shared step unit in a given state (X outside CH_n).
  function automatic chan_e state_chan(input state_e s);
    chan_e c;
    case (s)
      ST_CH_Y: c = CHAN_Y;
      ST_CH_Z: c = CHAN_Z;
      ST_CH_G: c = CHAN_G;
      default: c = CHAN_X;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/servo_slew_step.sv
// Combinational clamp-then-slew for one channel: next width from (cur, target).
module servo_slew_step
  import servo_pkg::*;
#(
  parameter int unsigned MIN_PULSE = MIN_PULSE_DEF,
  parameter int unsigned MAX_PULSE = MAX_PULSE_DEF,
  parameter int unsigned STEP      = STEP_DEF
) (
  input  logic [PULSE_W-1:0] cur,
  input  logic [PULSE_W-1:0] target,
  output logic [PULSE_W-1:0] nxt
);
  localparam int unsigned DW = PULSE_W + 1;
  localparam logic [PULSE_W-1:0] MIN_W  = PULSE_W'(MIN_PULSE);
  localparam logic [PULSE_W-1:0] MAX_W  = PULSE_W'(MAX_PULSE);
  localparam logic [PULSE_W-1:0] STEP_W = PULSE_W'(STEP);
  localparam logic signed [DW-1:0] STEP_S = DW'(STEP);

  logic [PULSE_W-1:0]      clamped;
  logic signed [DW-1:0]    diff;

  always_comb begin
    clamped = target;
    if (target < MIN_W) begin
      clamped = MIN_W;
    end else if (target > MAX_W) begin
      clamped = MAX_W;
    end
    // One extra bit keeps the difference exact in both directions.
    diff = $signed({1'b0, clamped}) - $signed({1'b0, cur});
    nxt  = clamped;
    if (diff > STEP_S) begin
      nxt = cur + STEP_W;
    end else if (diff < -STEP_S) begin
      nxt = cur - STEP_W;
    end
  end
endmodule

// File: rtl/servo_slew_limiter.sv
// Per-frame rate limiter for four servo PWM widths, sequenced through one shared step unit.
module servo_slew_limiter
  import servo_pkg::*;
#(
  parameter int unsigned MIN_PULSE    = MIN_PULSE_DEF,
  parameter int unsigned MAX_PULSE    = MAX_PULSE_DEF,
  parameter int unsigned CENTER_PULSE = CENTER_PULSE_DEF,
  parameter int unsigned STEP         = STEP_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               freeze,
  input  logic [PULSE_W-1:0] tgt_x,
  input  logic [PULSE_W-1:0] tgt_y,
  input  logic [PULSE_W-1:0] tgt_z,
  input  logic [PULSE_W-1:0] tgt_g,
  output logic [PULSE_W-1:0] pulse_x,
  output logic [PULSE_W-1:0] pulse_y,
  output logic [PULSE_W-1:0] pulse_z,
  output logic [PULSE_W-1:0] pulse_g,
  output logic               upd_done,
  output logic               busy,
  output logic               overrun
);
  localparam logic [PULSE_W-1:0] MIN_W    = PULSE_W'(MIN_PULSE);
  localparam logic [PULSE_W-1:0] CENTER_W = PULSE_W'(CENTER_PULSE);

  state_e             state_q, state_d;
  logic [PULSE_W-1:0] cur_q    [NUM_CH];
  logic [PULSE_W-1:0] cur_d    [NUM_CH];
  logic [PULSE_W-1:0] shadow_q [NUM_CH];
  logic [PULSE_W-1:0] shadow_d [NUM_CH];
  logic               overrun_q, overrun_d;

  chan_e              sel;
  logic [PULSE_W-1:0] step_cur, step_tgt, step_nxt;

  assign sel      = state_chan(state_q);
  assign step_cur = cur_q[sel];
  assign step_tgt = shadow_q[sel];

  servo_slew_step #(
    .MIN_PULSE (MIN_PULSE),
    .MAX_PULSE (MAX_PULSE),
    .STEP      (STEP)
  ) u_step (
    .cur    (step_cur),
    .target (step_tgt),
    .nxt    (step_nxt)
  );

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    shadow_d  = shadow_q;
    overrun_d = overrun_q;
    case (state_q)
      ST_IDLE: if (frame_tick) state_d = ST_SNAP;
      ST_SNAP: begin
        shadow_d[CHAN_X] = tgt_x;
        shadow_d[CHAN_Y] = tgt_y;
        shadow_d[CHAN_Z] = tgt_z;
        shadow_d[CHAN_G] = tgt_g;
        state_d          = ST_CH_X;
      end
      ST_CH_X, ST_CH_Y, ST_CH_Z, ST_CH_G: begin
        if (!freeze) cur_d[sel] = step_nxt;
        case (state_q)
          ST_CH_X: state_d = ST_CH_Y;
          ST_CH_Y: state_d = ST_CH_Z;
          ST_CH_Z: state_d = ST_CH_G;
          default: state_d = ST_DONE;
        endcase
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A tick during any busy state, DONE included, is dropped and flagged.
    if (frame_tick && state_q != ST_IDLE) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      overrun_q        <= 1'b0;
      cur_q[CHAN_X]    <= CENTER_W;
      cur_q[CHAN_Y]    <= CENTER_W;
      cur_q[CHAN_Z]    <= CENTER_W;
      cur_q[CHAN_G]    <= MIN_W;
      shadow_q[CHAN_X] <= CENTER_W;
      shadow_q[CHAN_Y] <= CENTER_W;
      shadow_q[CHAN_Z] <= CENTER_W;
      shadow_q[CHAN_G] <= MIN_W;
    end else begin
      state_q   <= state_d;
      overrun_q <= overrun_d;
      cur_q     <= cur_d;
      shadow_q  <= shadow_d;
    end
  end

  assign pulse_x  = cur_q[CHAN_X];
  assign pulse_y  = cur_q[CHAN_Y];
  assign pulse_z  = cur_q[CHAN_Z];
  assign pulse_g  = cur_q[CHAN_G];
  assign busy     = (state_q != ST_IDLE);
  assign upd_done = (state_q == ST_DONE);
  assign overrun  = overrun_q;
endmodule

// File: tb/tb_servo_slew_limiter.sv
// Self-checking bench for servo_slew_limiter: vector table, corner sequences, randomized frames.
module tb_servo_slew_limiter;
  localparam int MINP = 25_000;
  localparam int MAXP = 125_000;
  localparam int CEN  = 65_000;
  localparam int STP  = 1_000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_tick = 1'b0;
  logic        freeze = 1'b0;
  logic [19:0] tgt_x = 20'(CEN), tgt_y = 20'(CEN), tgt_z = 20'(CEN), tgt_g = 20'(MINP);
  logic [19:0] pulse_x, pulse_y, pulse_z, pulse_g;
  logic        upd_done, busy, overrun;

  int checks = 0;
  int failures = 0;
  int m[4];

  servo_slew_limiter dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .freeze     (freeze),
    .tgt_x      (tgt_x),
    .tgt_y      (tgt_y),
    .tgt_z      (tgt_z),
    .tgt_g      (tgt_g),
    .pulse_x    (pulse_x),
    .pulse_y    (pulse_y),
    .pulse_z    (pulse_z),
    .pulse_g    (pulse_g),
    .upd_done   (upd_done),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL timeout: bench did not finish (actual=running required=finished)");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference rule: clamp target into range, then move at most STP toward it.
  function automatic int model_step(input int cur, input int tgt);
    int c;
    c = (tgt < MINP) ? MINP : ((tgt > MAXP) ? MAXP : tgt);
    if (c > cur + STP) return cur + STP;
    if (c < cur - STP) return cur - STP;
    return c;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " pulse_x"}, int'(pulse_x), CEN);
    check({tag, " pulse_y"}, int'(pulse_y), CEN);
    check({tag, " pulse_z"}, int'(pulse_z), CEN);
    check({tag, " pulse_g"}, int'(pulse_g), MINP);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " upd_done"}, int'(upd_done), 0);
    check({tag, " overrun"}, int'(overrun), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m = '{CEN, CEN, CEN, MINP};
  endtask

  // Tick at k=0 (and optionally again at second_k); observe 10 cycles.
  task automatic run_frame(input int second_k, output int busy_cnt, output int done_cnt,
                           output int done_k);
    busy_cnt = 0;
    done_cnt = 0;
    done_k   = -1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k > 0) begin
        if (busy) busy_cnt++;
        if (upd_done) begin
          done_cnt++;
          if (done_k < 0) done_k = k;
        end
      end
      frame_tick = (k == 0 || k == second_k);
    end
    frame_tick = 1'b0;
  endtask

  task automatic frame_and_check(input string tag);
    int b, d, dk;
    int tg[4];
    tg = '{int'(tgt_x), int'(tgt_y), int'(tgt_z), int'(tgt_g)};
    if (!freeze) for (int i = 0; i < 4; i++) m[i] = model_step(m[i], tg[i]);
    run_frame(-1, b, d, dk);
    check({tag, " busy_cycles"}, b, 6);
    check({tag, " upd_done_count"}, d, 1);
    check({tag, " upd_done_cycle"}, dk, 6);
    check({tag, " pulse_x"}, int'(pulse_x), m[0]);
    check({tag, " pulse_y"}, int'(pulse_y), m[1]);
    check({tag, " pulse_z"}, int'(pulse_z), m[2]);
    check({tag, " pulse_g"}, int'(pulse_g), m[3]);
    $display("frame %s: x=%0d y=%0d z=%0d g=%0d", tag, pulse_x, pulse_y, pulse_z, pulse_g);
  endtask

  typedef struct {
    int tx, ty, tz, tg;
    bit frz;
    int ex, ey, ez, eg;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int b, d, dk, prev_y, prev_z;

    vecs[0] = '{70_500, CEN, CEN, MINP, 1'b0, 66_000, CEN, CEN, MINP};
    vecs[1] = '{70_500, CEN, CEN, MINP, 1'b0, 67_000, CEN, CEN, MINP};
    vecs[2] = '{70_500, CEN, CEN, MINP, 1'b0, 68_000, CEN, CEN, MINP};
    vecs[3] = '{70_500, CEN, CEN, MINP, 1'b0, 69_000, CEN, CEN, MINP};
    vecs[4] = '{70_500, CEN, CEN, MINP, 1'b0, 70_000, CEN, CEN, MINP};
    vecs[5] = '{70_500, CEN, CEN, MINP, 1'b0, 70_500, CEN, CEN, MINP};
    vecs[6] = '{70_500, CEN, CEN, MINP, 1'b0, 70_500, CEN, CEN, MINP};
    vecs[7] = '{69_800, CEN, CEN, MINP, 1'b1, 70_500, CEN, CEN, MINP};
    vecs[8] = '{69_800, CEN, CEN, MINP, 1'b0, 69_800, CEN, CEN, MINP};

    // Reset held, then released with no tick.
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_held");
    rst = 1'b1;
    m = '{CEN, CEN, CEN, MINP};
    repeat (5) @(negedge clk);
    check_reset_outputs("reset_released");

    // Vector table: slew sequence and a frozen frame.
    for (int i = 0; i < 9; i++) begin
      tgt_x  = 20'(vecs[i].tx);
      tgt_y  = 20'(vecs[i].ty);
      tgt_z  = 20'(vecs[i].tz);
      tgt_g  = 20'(vecs[i].tg);
      freeze = vecs[i].frz;
      frame_and_check($sformatf("vec%0d", i));
      check($sformatf("vec%0d table_x", i), int'(pulse_x), vecs[i].ex);
      check($sformatf("vec%0d table_y", i), int'(pulse_y), vecs[i].ey);
      check($sformatf("vec%0d table_z", i), int'(pulse_z), vecs[i].ez);
      check($sformatf("vec%0d table_g", i), int'(pulse_g), vecs[i].eg);
    end
    freeze = 1'b0;

    // Clamps: out-of-range targets converge at most STP per frame.
    tgt_y = 20'(200_000);
    tgt_z = 20'(0);
    for (int i = 0; i < 62; i++) begin
      prev_y = int'(pulse_y);
      prev_z = int'(pulse_z);
      frame_and_check($sformatf("clamp%0d", i));
      check("clamp_y_bounded", int'((int'(pulse_y) - prev_y) <= STP && int'(pulse_y) <= MAXP), 1);
      check("clamp_z_bounded", int'((prev_z - int'(pulse_z)) <= STP && int'(pulse_z) >= MINP), 1);
    end
    check("clamp_y_final", int'(pulse_y), MAXP);
    check("clamp_z_final", int'(pulse_z), MINP);

    // Freeze holds outputs while frames keep completing.
    freeze = 1'b1;
    tgt_g  = 20'(MAXP);
    for (int i = 0; i < 3; i++) begin
      frame_and_check($sformatf("freeze%0d", i));
      check("freeze_g_held", int'(pulse_g), MINP);
    end
    freeze = 1'b0;

    // Overrun: second tick 3 cycles into the frame is dropped.
    do_reset();
    check("overrun_after_reset", int'(overrun), 0);
    tgt_x = 20'(80_000);
    tgt_y = 20'(CEN);
    tgt_z = 20'(CEN);
    tgt_g = 20'(MINP);
    run_frame(3, b, d, dk);
    $display("overrun frame: busy=%0d done=%0d at=%0d overrun=%0d", b, d, dk, overrun);
    check("overrun_flag", int'(overrun), 1);
    check("overrun_done_count", d, 1);
    check("overrun_done_cycle", dk, 6);
    check("overrun_busy_cycles", b, 6);
    check("overrun_pulse_x", int'(pulse_x), model_step(CEN, 80_000));

    // Tick coincident with DONE: flagged, not queued.
    do_reset();
    run_frame(6, b, d, dk);
    $display("done-tick frame: busy=%0d done=%0d overrun=%0d", b, d, overrun);
    check("donetick_flag", int'(overrun), 1);
    check("donetick_busy_cycles", b, 6);
    check("donetick_done_count", d, 1);
    check("donetick_pulse_x", int'(pulse_x), model_step(model_step(CEN, 80_000), 80_000) - STP);

    // Mid-frame reset during CH_Y.
    do_reset();
    tgt_x = 20'(90_000);
    tgt_y = 20'(90_000);
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      frame_tick = (k == 0);
    end
    check("midreset_busy_before", int'(busy), 1);
    check("midreset_x_written", int'(pulse_x), CEN + STP);
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset_asserted");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    b = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy) b++;
    end
    check("midreset_no_restart", b, 0);
    check_reset_outputs("midreset_released");

    // Randomized frames against the reference model.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      tgt_x  = 20'($urandom_range(0, 150_000));
      tgt_y  = 20'($urandom_range(0, 150_000));
      tgt_z  = 20'(m[2] + int'($urandom_range(0, 3000)) - 1500);
      tgt_g  = 20'($urandom_range(0, 1_048_575));
      freeze = ($urandom_range(0, 3) == 0);
      frame_and_check($sformatf("rand%0d", i));
    end
    freeze = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
